// File: rtl/ft_tx_serializer_pkg.sv
// Shared definitions for the FTDI transmit serializer: state encoding,
// byte counts per header and per data word, and the response word-count rule.
package ft_tx_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR       = 3'd1,
    ST_WAIT_WORD = 3'd2,
    ST_DATA      = 3'd3,
    ST_FLUSH     = 3'd4
  } state_t;

  localparam logic [3:0] HDR_BYTES  = 4'd12;
  localparam logic [3:0] WORD_BYTES = 4'd4;

  // A response always carries at least the data word sent in the header.
  function automatic logic [27:0] eff_word_count(input logic [27:0] cnt);
    logic [27:0] res;
    if (cnt == 28'd0) begin
      res = 28'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/ft_word_shifter.sv
// 32-bit load / shift-by-8 register; the byte on the FTDI bus is always
// the most significant byte of the held word.
module ft_word_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] load_word,
  output logic [7:0]  msb_byte
);

  logic [31:0] word_r;

  // Word register: a load wins over a shift so word boundaries need no idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= 32'd0;
    end else if (load) begin
      word_r <= load_word;
    end else if (shift) begin
      word_r <= {word_r[23:0], 8'd0};
    end else begin
      word_r <= word_r;
    end
  end

  assign msb_byte = word_r[31:24];

endmodule

// File: rtl/ft_tx_serializer.sv
// Serializes a wishbone response (status, address, data, burst words) into
// MSB-first bytes for an FTDI synchronous FIFO, honouring its TXE# flow control.
module ft_tx_serializer
  import ft_tx_serializer_pkg::*;
#(
  parameter logic SIWU_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        oh_ready,
  input  logic        oh_en,
  input  logic [31:0] out_status,
  input  logic [31:0] out_address,
  input  logic [31:0] out_data,
  input  logic [27:0] out_data_count,
  input  logic        ftdi_txe_n,
  output logic        ftdi_wr_n,
  output logic [7:0]  ftdi_data_o,
  output logic        ftdi_data_oe,
  output logic        ftdi_siwu
);

  localparam logic [3:0] HDR_LAST  = HDR_BYTES - 4'd1;
  localparam logic [3:0] WORD_LAST = WORD_BYTES - 4'd1;
  localparam logic [3:0] ADDR_LAST = WORD_BYTES + WORD_BYTES - 4'd1;

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  byte_idx_r;
  logic [3:0]  byte_idx_next_s;
  logic [27:0] remaining_r;
  logic [27:0] remaining_next_s;
  logic [31:0] address_r;
  logic [31:0] data_r;
  logic        hdr_capture_s;
  logic        shift_load_s;
  logic        shift_en_s;
  logic [31:0] shift_word_s;
  logic        xfer_s;
  logic        oh_ready_r;
  logic        data_oe_r;
  logic        siwu_r;

  assign xfer_s = ((state_r == ST_HDR) || (state_r == ST_DATA)) && !ftdi_txe_n;

  // Next-state, byte index, word counter and shifter control.
  always_comb begin
    state_next_s     = state_r;
    byte_idx_next_s  = byte_idx_r;
    remaining_next_s = remaining_r;
    hdr_capture_s    = 1'b0;
    shift_load_s     = 1'b0;
    shift_en_s       = 1'b0;
    shift_word_s     = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (oh_en) begin
          hdr_capture_s    = 1'b1;
          shift_load_s     = 1'b1;
          shift_word_s     = out_status;
          byte_idx_next_s  = 4'd0;
          remaining_next_s = eff_word_count(out_data_count);
          state_next_s     = ST_HDR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_HDR, ST_DATA: begin
        if (xfer_s) begin
          if (((state_r == ST_HDR) && (byte_idx_r == HDR_LAST)) ||
              ((state_r == ST_DATA) && (byte_idx_r == WORD_LAST))) begin
            byte_idx_next_s = 4'd0;
            if (remaining_r > 28'd1) begin
              remaining_next_s = remaining_r - 28'd1;
              state_next_s     = ST_WAIT_WORD;
            end else begin
              state_next_s = ST_FLUSH;
            end
          end else begin
            byte_idx_next_s = byte_idx_r + 4'd1;
            // Header word boundaries reload the shifter with the next latched word.
            if ((state_r == ST_HDR) && (byte_idx_r == WORD_LAST)) begin
              shift_load_s = 1'b1;
              shift_word_s = address_r;
            end else if ((state_r == ST_HDR) && (byte_idx_r == ADDR_LAST)) begin
              shift_load_s = 1'b1;
              shift_word_s = data_r;
            end else begin
              shift_en_s = 1'b1;
            end
          end
        end else begin
          state_next_s = state_r;
        end
      end
      ST_WAIT_WORD: begin
        if (oh_en) begin
          shift_load_s    = 1'b1;
          shift_word_s    = out_data;
          byte_idx_next_s = 4'd0;
          state_next_s    = ST_DATA;
        end else begin
          state_next_s = ST_WAIT_WORD;
        end
      end
      ST_FLUSH: begin
        remaining_next_s = 28'd0;
        state_next_s     = ST_IDLE;
      end
      default: begin
        remaining_next_s = 28'd0;
        byte_idx_next_s  = 4'd0;
        state_next_s     = ST_IDLE;
      end
    endcase
  end

  // State, counters and header latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      byte_idx_r  <= 4'd0;
      remaining_r <= 28'd0;
      address_r   <= 32'd0;
      data_r      <= 32'd0;
    end else begin
      state_r     <= state_next_s;
      byte_idx_r  <= byte_idx_next_s;
      remaining_r <= remaining_next_s;
      if (hdr_capture_s) begin
        address_r <= out_address;
        data_r    <= out_data;
      end else begin
        address_r <= address_r;
        data_r    <= data_r;
      end
    end
  end

  // Handshake and bus-control outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oh_ready_r <= 1'b1;
      data_oe_r  <= 1'b0;
      siwu_r     <= 1'b1;
    end else begin
      oh_ready_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_WAIT_WORD);
      data_oe_r  <= (state_next_s == ST_HDR) || (state_next_s == ST_DATA) ||
                    (state_next_s == ST_FLUSH);
      siwu_r     <= !(SIWU_EN && (state_next_s == ST_FLUSH));
    end
  end

  ft_word_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (shift_load_s),
    .shift     (shift_en_s),
    .load_word (shift_word_s),
    .msb_byte  (ftdi_data_o)
  );

  assign oh_ready     = oh_ready_r;
  assign ftdi_data_oe = data_oe_r;
  assign ftdi_siwu    = siwu_r;
  assign ftdi_wr_n    = !xfer_s;

endmodule

// File: tb/tb_ft_tx_serializer.sv
// Self-checking bench: directed and randomized responses against a byte-stream
// model, one DUT with SIWU enabled and one with it disabled on shared inputs.
module tb_ft_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        oh_en = 1'b0;
  logic [31:0] out_status = 32'd0;
  logic [31:0] out_address = 32'd0;
  logic [31:0] out_data = 32'd0;
  logic [27:0] out_data_count = 28'd0;
  logic        ftdi_txe_n = 1'b0;

  logic        oh_ready, ftdi_wr_n, ftdi_data_oe, ftdi_siwu;
  logic [7:0]  ftdi_data_o;
  logic        oh_ready_0, ftdi_wr_n_0, ftdi_data_oe_0, ftdi_siwu_0;
  logic [7:0]  ftdi_data_o_0;

  bit txe_force = 1'b0;
  bit rand_txe  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] got0_q[$];
  int siwu_cnt = 0;
  int siwu0_cnt = 0;
  int viol_cnt = 0;

  always #5 clk = ~clk;

  ft_tx_serializer #(.SIWU_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .oh_ready(oh_ready), .oh_en(oh_en),
    .out_status(out_status), .out_address(out_address), .out_data(out_data),
    .out_data_count(out_data_count), .ftdi_txe_n(ftdi_txe_n), .ftdi_wr_n(ftdi_wr_n),
    .ftdi_data_o(ftdi_data_o), .ftdi_data_oe(ftdi_data_oe), .ftdi_siwu(ftdi_siwu)
  );

  ft_tx_serializer #(.SIWU_EN(1'b0)) dut_nosiwu (
    .clk(clk), .rst_n(rst_n), .oh_ready(oh_ready_0), .oh_en(oh_en),
    .out_status(out_status), .out_address(out_address), .out_data(out_data),
    .out_data_count(out_data_count), .ftdi_txe_n(ftdi_txe_n), .ftdi_wr_n(ftdi_wr_n_0),
    .ftdi_data_o(ftdi_data_o_0), .ftdi_data_oe(ftdi_data_oe_0), .ftdi_siwu(ftdi_siwu_0)
  );

  // FIFO-space driver: forced stall, random back-pressure, or always ready.
  always @(posedge clk) begin
    #1;
    ftdi_txe_n = txe_force ? 1'b1 : (rand_txe ? ($urandom_range(0, 3) == 0) : 1'b0);
  end

  // Bus monitor: records written bytes, SIWU pulses and handshake violations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!ftdi_wr_n) begin
        got_q.push_back(ftdi_data_o);
        if (oh_ready || !ftdi_data_oe) viol_cnt++;
      end
      if (!ftdi_wr_n_0) got0_q.push_back(ftdi_data_o_0);
      if (!ftdi_siwu) siwu_cnt++;
      if (!ftdi_siwu_0) siwu0_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic run_resp(input logic [31:0] st, input logic [31:0] ad,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3,
                          input int cnt, input int ww_delay, input int stall_at,
                          input int abort_at, input bit b2b, input int settle);
    logic [31:0] words[4];
    logic [7:0]  exp_q[$];
    int eff, base, base0, sbase, s0base, vbase, waited, bad;
    words = '{w0, w1, w2, w3};
    eff = (cnt == 0) ? 1 : cnt;
    for (int b = 3; b >= 0; b--) exp_q.push_back(8'(st >> (8 * b)));
    for (int b = 3; b >= 0; b--) exp_q.push_back(8'(ad >> (8 * b)));
    for (int w = 0; w < eff; w++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'(words[w] >> (8 * b)));
    base = got_q.size(); base0 = got0_q.size();
    sbase = siwu_cnt; s0base = siwu0_cnt; vbase = viol_cnt;

    waited = 0;
    do begin @(negedge clk); waited++; end while (!oh_ready && waited < 300);
    check_val("idle_ready", oh_ready, 1);
    check_val("idle_oe", ftdi_data_oe, 0);
    if (b2b) check_val("b2b_wait", waited, 1);
    #2;
    oh_en = 1'b1; out_status = st; out_address = ad; out_data = words[0];
    out_data_count = 28'(cnt);
    @(posedge clk); #1;
    oh_en = 1'b0; out_status = $urandom; out_address = $urandom; out_data = $urandom;
    out_data_count = 28'($urandom);

    if (!rand_txe) begin
      @(negedge clk);
      check_val("lat_wr_n", ftdi_wr_n, 0);
      check_val("lat_byte", ftdi_data_o, st[31:24]);
    end

    if (stall_at > 0) begin
      waited = 0;
      do begin @(negedge clk); #2; waited++; end
        while ((got_q.size() - base) < stall_at && waited < 200);
      txe_force = 1'b1;
      bad = 0;
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        if (ftdi_wr_n !== 1'b1 || ftdi_data_o !== exp_q[stall_at]) bad++;
      end
      txe_force = 1'b0;
      check_val("stall_hold", bad, 0);
    end

    if (abort_at > 0) begin
      waited = 0;
      do begin @(negedge clk); #2; waited++; end
        while ((got_q.size() - base) < abort_at && waited < 200);
      rst_n = 1'b0;
      #1;
      check_val("abort_wr_n", ftdi_wr_n, 1);
      @(negedge clk);
      check_val("abort_wr_n_next", ftdi_wr_n, 1);
      check_val("abort_oe", ftdi_data_oe, 0);
      check_val("abort_ready", oh_ready, 1);
      #2 rst_n = 1'b1;
      return;
    end

    for (int w = 1; w < eff; w++) begin
      waited = 0;
      do begin @(negedge clk); #2; waited++; end while (!oh_ready && waited < 300);
      check_val("ww_ready", oh_ready, 1);
      bad = 0;
      for (int d = 0; d < ww_delay; d++) begin
        @(negedge clk);
        if (ftdi_data_oe !== 1'b0 || oh_ready !== 1'b1 || ftdi_wr_n !== 1'b1) bad++;
      end
      check_val("ww_idle", bad, 0);
      oh_en = 1'b1; out_data = words[w];
      @(posedge clk); #1;
      oh_en = 1'b0; out_data = $urandom;
    end

    waited = 0;
    do begin @(negedge clk); #2; waited++; end
      while (((got_q.size() - base) < exp_q.size() || siwu_cnt == sbase) && waited < 400);
    check_val("n_bytes", got_q.size() - base, exp_q.size());
    check_val("n_bytes_nosiwu", got0_q.size() - base0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) check_val("byte", got_q[base + i], exp_q[i]);
      if (base0 + i < got0_q.size()) check_val("byte_nosiwu", got0_q[base0 + i], exp_q[i]);
    end
    check_val("siwu_pulses", siwu_cnt - sbase, 1);
    check_val("nosiwu_pulses", siwu0_cnt - s0base, 0);
    check_val("ready_oe_viol", viol_cnt - vbase, 0);
    repeat (settle) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_ready", oh_ready, 1);
    check_val("rst_wr_n", ftdi_wr_n, 1);
    check_val("rst_siwu", ftdi_siwu, 1);
    check_val("rst_oe", ftdi_data_oe, 0);
    check_val("rst_data", ftdi_data_o, 0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_resp(32'hFFFFFFFE, 32'h01000000, 32'h01234567, 32'd0, 32'd0, 32'd0,
             1, 0, 0, 0, 1'b0, 0);
    run_resp(32'h5A5A0001, 32'h00000040, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'd0,
             3, 5, 0, 0, 1'b1, 2);
    run_resp(32'h11223344, 32'h55667788, 32'h99AABBCC, 32'd0, 32'd0, 32'd0,
             1, 0, 5, 0, 1'b0, 1);
    run_resp(32'hCAFEF00D, 32'h00001000, 32'hDEADBEEF, 32'h0BADF00D, 32'd0, 32'd0,
             0, 0, 0, 0, 1'b0, 1);
    run_resp(32'h0F0F0F0F, 32'hF0F0F0F0, 32'h12345678, 32'd0, 32'd0, 32'd0,
             1, 0, 0, 8, 1'b0, 0);
    repeat (2) @(negedge clk);
    run_resp(32'h87654321, 32'h00ABCDEF, 32'h76543210, 32'd0, 32'd0, 32'd0,
             1, 0, 0, 0, 1'b0, 0);

    rand_txe = 1'b1;
    for (int r = 0; r < 8; r++) begin
      run_resp($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom_range(0, 4), $urandom_range(0, 4), 0, 0, 1'b0,
               $urandom_range(0, 2));
    end
    rand_txe = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
